// File: rtl/sudoku_group_scanner.sv
`default_nettype none
// ============================================================================
// Module   : sudoku_group_scanner
// Purpose  : Loads a 9x9 board one cell per cycle, then presents each of the
//            27 row/column/box groups to an external uniqueness checker and
//            reports the first failing group.
// Options  : SUDOKU_RANGE_CHECK_EN - reject boards holding cells outside 1..9
// Revision : 1.0 - initial release
// ============================================================================
module sudoku_group_scanner (
  input  logic       clock,
  input  logic       reset,
  input  logic       cell_valid,
  input  logic [3:0] cell_in,
  output logic       cell_ready,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [3:0] num5,
  output logic [3:0] num6,
  output logic [3:0] num7,
  output logic [3:0] num8,
  output logic [3:0] num9,
  input  logic       unique_valid,
  output logic       busy,
  output logic       done,
  output logic       board_valid,
  output logic [4:0] bad_group
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] c_last_cell  = 7'd80;
  localparam logic [4:0] c_last_group = 5'd26;
  localparam logic [4:0] c_no_fail    = 5'd31;
  localparam logic [4:0] c_range_fail = 5'd30;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_grid [0:80];
  logic [6:0] r_load_idx;
  logic [4:0] r_group_idx;
  logic       r_board_valid;
  logic [4:0] r_bad_group;
  logic       w_accept;
  logic       w_last_accept;
  logic       w_range_abort;
  logic [3:0] w_num [0:8];

  // Flat grid address of member j of group g (rows 0-8, columns 9-17, boxes 18-26).
  function automatic logic [6:0] cell_index(input logic [4:0] g, input int j);
    int gi;
    int b;
    gi = int'(g);
    b  = gi - 18;
    if (gi < 9)
      return 7'(gi * 9 + j);
    else if (gi < 18)
      return 7'(j * 9 + gi - 9);
    else
      return 7'(((b / 3) * 3 + j / 3) * 9 + (b % 3) * 3 + j % 3);
  endfunction

  assign w_accept      = cell_valid && (r_state == S_LOAD);
  assign w_last_accept = w_accept && (r_load_idx == c_last_cell);

`ifdef SUDOKU_RANGE_CHECK_EN
  logic r_range_err;
  logic w_cell_bad;

  assign w_cell_bad    = (cell_in == 4'd0) || (cell_in > 4'd9);
  // The final cell itself counts toward the abort decision.
  assign w_range_abort = r_range_err || w_cell_bad;

  always_ff @(posedge clock) begin
    if (reset || (r_state == S_DONE))
      r_range_err <= 1'b0;
    else if (w_accept && w_cell_bad)
      r_range_err <= 1'b1;
  end
`else
  assign w_range_abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_LOAD;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD: if (w_last_accept) w_next_state = w_range_abort ? S_DONE : S_SCAN;
      S_SCAN: if (!unique_valid || (r_group_idx == c_last_group)) w_next_state = S_DONE;
      S_DONE: w_next_state = S_LOAD;
      default: w_next_state = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_accept)
      r_grid[r_load_idx] <= cell_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_idx    <= '0;
      r_group_idx   <= '0;
      r_board_valid <= 1'b0;
      r_bad_group   <= c_no_fail;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (r_load_idx == '0) begin
              r_board_valid <= 1'b0;
              r_bad_group   <= c_no_fail;
            end
            if (w_last_accept) begin
              r_load_idx  <= '0;
              r_group_idx <= '0;
              if (w_range_abort) begin
                r_board_valid <= 1'b0;
                r_bad_group   <= c_range_fail;
              end
            end else begin
              r_load_idx <= r_load_idx + 7'd1;
            end
          end
        end
        S_SCAN: begin
          if (!unique_valid) begin
            r_bad_group   <= r_group_idx;
            r_board_valid <= 1'b0;
          end else if (r_group_idx == c_last_group) begin
            r_board_valid <= 1'b1;
            r_bad_group   <= c_no_fail;
          end else begin
            r_group_idx <= r_group_idx + 5'd1;
          end
        end
        S_DONE: r_group_idx <= '0;
        default: r_group_idx <= '0;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < 9; j++) begin
      w_num[j] = '0;
      if (r_state == S_SCAN)
        w_num[j] = r_grid[cell_index(r_group_idx, j)];
    end
  end

  assign num1        = w_num[0];
  assign num2        = w_num[1];
  assign num3        = w_num[2];
  assign num4        = w_num[3];
  assign num5        = w_num[4];
  assign num6        = w_num[5];
  assign num7        = w_num[6];
  assign num8        = w_num[7];
  assign num9        = w_num[8];
  assign cell_ready  = (r_state == S_LOAD);
  assign busy        = (r_state != S_LOAD);
  assign done        = (r_state == S_DONE);
  assign board_valid = r_board_valid;
  assign bad_group   = r_bad_group;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_group_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sudoku_group_scanner
// Purpose  : Directed bench for sudoku_group_scanner with a behavioural
//            uniqueness checker closing the loop on num1..num9.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sudoku_group_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic       cell_valid;
  logic [3:0] cell_in;
  logic       cell_ready;
  logic [3:0] num1, num2, num3, num4, num5, num6, num7, num8, num9;
  logic       unique_valid;
  logic       busy;
  logic       done;
  logic       board_valid;
  logic [4:0] bad_group;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  int         rel    = 0;
  int         span;
  int         done_seen;
  logic [3:0] brd [0:80];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sudoku_group_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .cell_valid  (cell_valid),
    .cell_in     (cell_in),
    .cell_ready  (cell_ready),
    .num1        (num1),
    .num2        (num2),
    .num3        (num3),
    .num4        (num4),
    .num5        (num5),
    .num6        (num6),
    .num7        (num7),
    .num8        (num8),
    .num9        (num9),
    .unique_valid(unique_valid),
    .busy        (busy),
    .done        (done),
    .board_valid (board_valid),
    .bad_group   (bad_group)
  );

  // Downstream checker: nine cells pass only if they cover 1..9 exactly.
  always_comb begin
    logic [3:0] grp [0:8];
    logic [9:0] seen;
    grp[0] = num1; grp[1] = num2; grp[2] = num3;
    grp[3] = num4; grp[4] = num5; grp[5] = num6;
    grp[6] = num7; grp[7] = num8; grp[8] = num9;
    seen = '0;
    for (int k = 0; k < 9; k++)
      if (grp[k] >= 4'd1 && grp[k] <= 4'd9) seen[grp[k]] = 1'b1;
    unique_valid = &seen[9:1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
    rel++;
  endtask

  task automatic make_valid();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        brd[r * 9 + c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endtask

  // Leaves rel = 1, i.e. the cycle right after the index-80 accept.
  task automatic load_board(input bit gaps, output int load_span);
    int first;
    first = 0;
    for (int i = 0; i < 81; i++) begin
      cell_valid = 1'b1;
      cell_in    = brd[i];
      @(posedge clock); #1;
      if (i == 0) begin
        first = cyc;
        check("first_accept_board_valid", 32'(board_valid), 32'd0);
        check("first_accept_bad_group", 32'(bad_group), 32'd31);
      end
      if (gaps && i < 80) begin
        cell_valid = 1'b0;
        cell_in    = 4'hF;
        @(posedge clock); #1;
      end
    end
    cell_valid = 1'b0;
    cell_in    = 4'h0;
    load_span  = cyc - first + 1;
    rel        = 1;
  endtask

  task automatic wait_done(input string tag, input int k);
    while (!done && rel < 64) step();
    check(tag, 32'(rel), 32'(k));
  endtask

  initial begin
    reset      = 1'b1;
    cell_valid = 1'b0;
    cell_in    = 4'h0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    check("rst_cell_ready", 32'(cell_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_board_valid", 32'(board_valid), 32'd0);
    check("rst_bad_group", 32'(bad_group), 32'd31);
    check("rst_num1", 32'(num1), 32'd0);

    // Valid board, gap-free load.
    make_valid();
    load_board(1'b0, span);
    check("scan_busy", 32'(busy), 32'd1);
    check("scan_cell_ready", 32'(cell_ready), 32'd0);
    check("row0_num1", 32'(num1), 32'd1);
    check("row0_num5", 32'(num5), 32'd5);
    check("row0_num9", 32'(num9), 32'd9);
    while (rel < 12) step();
    check("col2_num1", 32'(num1), 32'd3);
    check("col2_num9", 32'(num9), 32'd2);
    while (rel < 20) step();
    check("box1_num1", 32'(num1), 32'd4);
    check("box1_num5", 32'(num5), 32'd8);
    check("box1_num9", 32'(num9), 32'd3);
    wait_done("pass_done_cycle", 28);
    check("pass_board_valid", 32'(board_valid), 32'd1);
    check("pass_bad_group", 32'(bad_group), 32'd31);
    check("pass_busy_in_done", 32'(busy), 32'd1);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(cell_ready), 32'd1);
    check("verdict_held", 32'(board_valid), 32'd1);

    // Row 4 duplicate.
    make_valid();
    brd[40] = brd[36];
    load_board(1'b0, span);
    wait_done("row4_done_cycle", 6);
    check("row4_board_valid", 32'(board_valid), 32'd0);
    check("row4_bad_group", 32'(bad_group), 32'd4);
    step();

    // Swap cells 0 and 1: column 0 is the first to fail.
    make_valid();
    brd[0] = brd[1];
    brd[1] = 4'd1;
    load_board(1'b0, span);
    wait_done("col0_done_cycle", 11);
    check("col0_board_valid", 32'(board_valid), 32'd0);
    check("col0_bad_group", 32'(bad_group), 32'd9);
    step();

    // Valid board with cell_valid low every other cycle.
    make_valid();
    load_board(1'b1, span);
    check("gap_load_span", 32'(span), 32'd161);
    wait_done("gap_done_cycle", 28);
    check("gap_board_valid", 32'(board_valid), 32'd1);
    check("gap_bad_group", 32'(bad_group), 32'd31);
    step();

    // Reset in the middle of the scan.
    make_valid();
    load_board(1'b0, span);
    while (rel < 10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_cell_ready", 32'(cell_ready), 32'd1);
    check("abort_bad_group", 32'(bad_group), 32'd31);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_board_valid", 32'(board_valid), 32'd0);
    check("abort_num1", 32'(num1), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 35; i++) begin
      if (done) done_seen++;
      step();
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    load_board(1'b0, span);
    wait_done("after_abort_done_cycle", 28);
    check("after_abort_board_valid", 32'(board_valid), 32'd1);
    step();

    // Cell 5 holds an out-of-range zero.
    make_valid();
    brd[5] = 4'd0;
    load_board(1'b0, span);
`ifdef SUDOKU_RANGE_CHECK_EN
    wait_done("range_done_cycle", 1);
    check("range_board_valid", 32'(board_valid), 32'd0);
    check("range_bad_group", 32'(bad_group), 32'd30);
`else
    wait_done("range_done_cycle", 2);
    check("range_board_valid", 32'(board_valid), 32'd0);
    check("range_bad_group", 32'(bad_group), 32'd0);
`endif
    step();
    check("range_ready_after", 32'(cell_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
